// File: rtl/fp_mul.sv
// Multi-cycle IEEE-754 binary32 multiplier: capture, unpack, multiply, normalise,
// round to nearest-even, then register the product on z.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | waiting for rdy; operands latched on the strobe
//  UNPACK | split fields, restore hidden bit, resolve special operands
//  MULT   | sign, exponent sum, 24x24 mantissa product
//  NORM   | align product to 24 bits, form guard/round/sticky
//  ROUND  | round to nearest even, renormalise on carry-out
//  PUT    | write z (special, underflow, overflow or normal result)
module fp_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z
);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, PUT} state_t;

    state_t             state;
    logic [31:0]        a_r, b_r;
    logic               sa, sb, zs;
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic               spec;
    logic [31:0]        spec_z;
    logic signed [9:0]  ze;
    logic [47:0]        prod;
    logic [23:0]        zm;
    logic               g, r, st;

    // Subnormals carry exponent 0 and are classified as zero (flush to zero).
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_ab, round_up;
    assign a_zero   = (a_r[30:23] == 8'h00);
    assign b_zero   = (b_r[30:23] == 8'h00);
    assign a_inf    = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'h0);
    assign b_inf    = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'h0);
    assign a_nan    = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'h0);
    assign b_nan    = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'h0);
    assign s_ab     = a_r[31] ^ b_r[31];
    assign round_up = g && (r || st || zm[0]);

    logic unused_bits;
    assign unused_bits = zm[23];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            z      <= 32'h0;
            a_r    <= 32'h0;
            b_r    <= 32'h0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            zs     <= 1'b0;
            ea     <= 8'h0;
            eb     <= 8'h0;
            ma     <= 24'h0;
            mb     <= 24'h0;
            spec   <= 1'b0;
            spec_z <= 32'h0;
            ze     <= 10'sd0;
            prod   <= 48'h0;
            zm     <= 24'h0;
            g      <= 1'b0;
            r      <= 1'b0;
            st     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sa <= a_r[31];
                    sb <= b_r[31];
                    ea <= a_r[30:23];
                    eb <= b_r[30:23];
                    ma <= {1'b1, a_r[22:0]};
                    mb <= {1'b1, b_r[22:0]};
                    if (a_nan || b_nan) begin
                        spec   <= 1'b1;
                        spec_z <= 32'h7FC00000;
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        spec   <= 1'b1;
                        spec_z <= 32'h7FC00000;
                    end else if (a_inf || b_inf) begin
                        spec   <= 1'b1;
                        spec_z <= {s_ab, 8'hFF, 23'h0};
                    end else if (a_zero || b_zero) begin
                        spec   <= 1'b1;
                        spec_z <= {s_ab, 31'h0};
                    end else begin
                        spec   <= 1'b0;
                        spec_z <= 32'h0;
                    end
                    state <= MULT;
                end
                MULT: begin
                    zs    <= sa ^ sb;
                    ze    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                    prod  <= {24'h0, ma} * {24'h0, mb};
                    state <= NORM;
                end
                NORM: begin
                    if (prod[47]) begin
                        zm <= prod[47:24];
                        g  <= prod[23];
                        r  <= prod[22];
                        st <= |prod[21:0];
                        ze <= ze + 10'sd1;
                    end else begin
                        zm <= prod[46:23];
                        g  <= prod[22];
                        r  <= prod[21];
                        st <= |prod[20:0];
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    if (round_up) begin
                        if (zm == 24'hFFFFFF) begin
                            zm <= 24'h800000;
                            ze <= ze + 10'sd1;
                        end else begin
                            zm <= zm + 24'd1;
                        end
                    end
                    state <= PUT;
                end
                PUT: begin
                    if (spec)
                        z <= spec_z;
                    else if (ze <= 10'sd0)
                        z <= {zs, 31'h0};
                    else if (ze >= 10'sd255)
                        z <= {zs, 8'hFF, 23'h0};
                    else
                        z <= {zs, ze[7:0], zm[22:0]};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// Directed-vector bench for fp_mul: latency, arithmetic, specials, rounding,
// ignored strobes and mid-flight reset.
module tb_fp_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] a, b;
    logic [31:0] z;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [31:0] last_z;

    fp_mul dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .a   (a),
        .b   (b),
        .z   (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One operation: strobe at the capture edge, scramble the inputs afterwards,
    // confirm z holds through edge 4 and shows the result after edge 5.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        a   = ta;
        b   = tb_v;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        a   = $urandom;
        b   = $urandom;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_hold"}, z, last_z);
        @(posedge clk);
        #1;
        check(tag, z, exp);
        last_z = exp;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        a   = 32'h0;
        b   = 32'h0;
        last_z = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", z, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40000000, 32'h40400000, 32'h40C00000, "two_x_three");
        run_op(32'h40400000, 32'h40400000, 32'h41100000, "three_sq");
        run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, "neg_sign");
        run_op(32'h00000000, 32'h40400000, 32'h00000000, "zero_x");
        run_op(32'h80000000, 32'h40400000, 32'h80000000, "negzero_x");
        run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, "neginf_x");
        run_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "overflow");
        run_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, "round_sticky");
        run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "round_norm");
        run_op(32'h00400000, 32'h40400000, 32'h00000000, "subnorm_flush");

        // rdy raised again while in MULT must be ignored.
        @(negedge clk);
        a = 32'h40000000; b = 32'h40400000; rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'h40400000; b = 32'h40400000; rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_rdy_first", z, 32'h40C00000);
        repeat (6) @(posedge clk);
        #1;
        check("busy_rdy_ignored", z, 32'h40C00000);
        last_z = 32'h40C00000;

        // Reset asserted while in NORM aborts the operation.
        @(negedge clk);
        a = 32'h40400000; b = 32'h40400000; rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_norm_z", z, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_result", z, 32'h0);
        last_z = 32'h0;

        run_op(32'hC0400000, 32'hC0000000, 32'h40C00000, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
